// File: rtl/xif_coproc_mux.sv
// X-interface fan-out: broadcast issue, route commit/mem-result to the owning unit, RR-arbitrate mem and result.
// Issue/commit/mem paths are combinational; result is a 1-entry register (1 cycle, full throughput); stalls via ready.
module xif_coproc_mux #(
   parameter int unsigned NrCoproc    = 2,
   parameter int unsigned IdWidth     = 4,
   parameter int unsigned InstrWidth  = 32,
   parameter int unsigned MemReqWidth = 80,
   parameter int unsigned ResultWidth = 64
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            issue_valid_i,
   output logic                            issue_ready_o,
   input  logic [IdWidth-1:0]              issue_id_i,
   input  logic [InstrWidth-1:0]           issue_instr_i,
   output logic                            issue_accept_o,
   output logic                            issue_writeback_o,
   output logic [NrCoproc-1:0]             cp_issue_valid_o,
   input  logic [NrCoproc-1:0]             cp_issue_ready_i,
   input  logic [NrCoproc-1:0]             cp_issue_accept_i,
   input  logic [NrCoproc-1:0]             cp_issue_writeback_i,
   input  logic                            commit_valid_i,
   input  logic [IdWidth-1:0]              commit_id_i,
   input  logic                            commit_kill_i,
   output logic [NrCoproc-1:0]             cp_commit_valid_o,
   input  logic [NrCoproc-1:0]             cp_mem_valid_i,
   output logic [NrCoproc-1:0]             cp_mem_ready_o,
   input  logic [NrCoproc*MemReqWidth-1:0] cp_mem_req_i,
   output logic                            mem_valid_o,
   input  logic                            mem_ready_i,
   output logic [MemReqWidth-1:0]          mem_req_o,
   input  logic                            mem_result_valid_i,
   output logic [NrCoproc-1:0]             cp_mem_result_valid_o,
   input  logic [NrCoproc-1:0]             cp_result_valid_i,
   output logic [NrCoproc-1:0]             cp_result_ready_o,
   input  logic [NrCoproc*ResultWidth-1:0] cp_result_i,
   output logic                            result_valid_o,
   input  logic                            result_ready_i,
   output logic [ResultWidth-1:0]          result_o,
   output logic                            conflict_o
);

   localparam int unsigned OwnW  = (NrCoproc > 1) ? $clog2(NrCoproc) : 1;
   localparam int unsigned Depth = 2**IdWidth;
   typedef logic [OwnW-1:0] own_t;

   function automatic own_t rr_pick(input logic [NrCoproc-1:0] req, input own_t ptr);
      own_t idx;
      own_t pick;
      logic found;
      idx   = ptr;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NrCoproc; i++) begin
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
         idx = (idx == own_t'(NrCoproc - 1)) ? '0 : idx + own_t'(1);
      end
      return pick;
   endfunction

   function automatic own_t rr_next(input own_t g);
      return (g == own_t'(NrCoproc - 1)) ? '0 : g + own_t'(1);
   endfunction

   logic [Depth-1:0]       tbl_vld_q, tbl_vld_d, tbl_wb_q, tbl_wb_d;
   own_t                   tbl_own_q [Depth];
   own_t                   tbl_own_d [Depth];
   logic                   conflict_q, conflict_d;
   logic                   res_vld_q, res_vld_d;
   logic [ResultWidth-1:0] res_dat_q, res_dat_d;
   own_t                   res_ptr_q, res_ptr_d;
   logic                   mem_lock_q, mem_lock_d;
   own_t                   mem_own_q, mem_own_d;
   own_t                   mem_ptr_q, mem_ptr_d;

   // The instruction word reaches the units on their own wiring; only the ID matters here.
   logic unused_instr;
   assign unused_instr = ^issue_instr_i;

   logic id_busy, issue_hs, issue_wr, acc_wb;
   own_t acc_own;

   assign id_busy           = tbl_vld_q[issue_id_i];
   assign cp_issue_valid_o  = {NrCoproc{issue_valid_i && !id_busy}};
   assign issue_ready_o     = (&cp_issue_ready_i) && !id_busy;
   assign issue_accept_o    = |cp_issue_accept_i;
   assign issue_writeback_o = acc_wb;
   assign issue_hs          = issue_valid_i && issue_ready_o;
   assign issue_wr          = issue_hs && issue_accept_o;

   always_comb begin
      acc_own = '0;
      acc_wb  = 1'b0;
      for (int i = NrCoproc - 1; i >= 0; i--) begin
         if (cp_issue_accept_i[i]) begin
            acc_own = own_t'(i);
            acc_wb  = cp_issue_writeback_i[i];
         end
      end
   end

   logic commit_hit, commit_free;
   assign commit_hit  = commit_valid_i && tbl_vld_q[commit_id_i];
   assign commit_free = commit_hit && (commit_kill_i || !tbl_wb_q[commit_id_i]);

   always_comb begin
      cp_commit_valid_o = '0;
      if (commit_hit) cp_commit_valid_o[tbl_own_q[commit_id_i]] = 1'b1;
   end

   logic                   res_load, res_any, res_pop;
   own_t                   res_gnt;
   logic [ResultWidth-1:0] res_sel_dat;

   assign res_load       = !res_vld_q || result_ready_i;
   assign res_any        = |cp_result_valid_i;
   assign res_gnt        = rr_pick(cp_result_valid_i, res_ptr_q);
   assign res_pop        = res_vld_q && result_ready_i;
   assign result_valid_o = res_vld_q;
   assign result_o       = res_dat_q;
   assign conflict_o     = conflict_q;

   always_comb begin
      cp_result_ready_o = '0;
      res_sel_dat       = '0;
      for (int i = 0; i < NrCoproc; i++) begin
         if (own_t'(i) == res_gnt) res_sel_dat = cp_result_i[i*ResultWidth +: ResultWidth];
      end
      if (res_load && res_any) cp_result_ready_o[res_gnt] = 1'b1;
   end

   logic mem_any, mem_hs;
   own_t mem_sel;

   assign mem_any     = |cp_mem_valid_i;
   assign mem_sel     = rr_pick(cp_mem_valid_i, mem_ptr_q);
   assign mem_valid_o = !mem_lock_q && mem_any;
   assign mem_hs      = mem_valid_o && mem_ready_i;

   always_comb begin
      mem_req_o             = '0;
      cp_mem_ready_o        = '0;
      cp_mem_result_valid_o = '0;
      for (int i = 0; i < NrCoproc; i++) begin
         if (mem_valid_o && own_t'(i) == mem_sel) mem_req_o = cp_mem_req_i[i*MemReqWidth +: MemReqWidth];
      end
      if (mem_valid_o) cp_mem_ready_o[mem_sel] = mem_ready_i;
      if (mem_lock_q && mem_result_valid_i) cp_mem_result_valid_o[mem_own_q] = 1'b1;
   end

   always_comb begin
      tbl_vld_d  = tbl_vld_q;
      tbl_wb_d   = tbl_wb_q;
      tbl_own_d  = tbl_own_q;
      conflict_d = conflict_q | (issue_hs && ($countones(cp_issue_accept_i) > 1));
      res_vld_d  = res_vld_q;
      res_dat_d  = res_dat_q;
      res_ptr_d  = res_ptr_q;
      mem_lock_d = mem_lock_q;
      mem_own_d  = mem_own_q;
      mem_ptr_d  = mem_ptr_q;

      // Frees first so that a same-cycle issue write to the same ID takes precedence.
      if (commit_free) tbl_vld_d[commit_id_i] = 1'b0;
      if (res_pop) tbl_vld_d[res_dat_q[IdWidth-1:0]] = 1'b0;
      if (issue_wr) begin
         tbl_vld_d[issue_id_i] = 1'b1;
         tbl_own_d[issue_id_i] = acc_own;
         tbl_wb_d[issue_id_i]  = acc_wb;
      end

      if (res_load) begin
         res_vld_d = res_any;
         if (res_any) begin
            res_dat_d = res_sel_dat;
            res_ptr_d = rr_next(res_gnt);
         end
      end

      if (mem_hs) begin
         mem_lock_d = 1'b1;
         mem_own_d  = mem_sel;
         mem_ptr_d  = rr_next(mem_sel);
      end else if (mem_lock_q && mem_result_valid_i) begin
         mem_lock_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tbl_vld_q  <= '0;
         tbl_wb_q   <= '0;
         for (int i = 0; i < Depth; i++) tbl_own_q[i] <= '0;
         conflict_q <= 1'b0;
         res_vld_q  <= 1'b0;
         res_dat_q  <= '0;
         res_ptr_q  <= '0;
         mem_lock_q <= 1'b0;
         mem_own_q  <= '0;
         mem_ptr_q  <= '0;
      end else begin
         tbl_vld_q  <= tbl_vld_d;
         tbl_wb_q   <= tbl_wb_d;
         tbl_own_q  <= tbl_own_d;
         conflict_q <= conflict_d;
         res_vld_q  <= res_vld_d;
         res_dat_q  <= res_dat_d;
         res_ptr_q  <= res_ptr_d;
         mem_lock_q <= mem_lock_d;
         mem_own_q  <= mem_own_d;
         mem_ptr_q  <= mem_ptr_d;
      end
   end

endmodule
